sub_chunked_serial: RTL and testbench

- Sequential chunked subtractor: computes C = A - B for N-bit operands, streamed W = N/CC bits per accepted beat, least-significant chunk first.
- Inverse counterpart of the chunked serial adder. Carries a registered borrow across beats in place of a carry.
- Adds start/done framing, a beat counter and valid/ready handshakes on both sides, so it can sit between operand feeders and a result collector in garbled-circuit test netlists.

---
 rtl/sub_chunked_pkg.sv | 36 +++
 rtl/sub_chunk_slice.sv | 34 +++
 rtl/sub_chunked_serial.sv | 152 +++++++++++++++
 tb/tb_sub_chunked_serial.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_chunked_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sub_chunked_pkg
// Desc     : Shared types and sizing helpers for the chunked serial add/sub.
// Revision : 1.0 - initial release
// ============================================================================
package sub_chunked_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_N  = 16384;
    localparam int DEF_CC = 1024;
    localparam int DEF_W  = DEF_N / DEF_CC;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // A one-beat operation still needs a 1-bit counter to exist.
    function automatic int cnt_width(input int cc);
        return (clog2(cc) < 1) ? 1 : clog2(cc);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sub_chunk_slice.sv
`default_nettype none
// ============================================================================
// Module   : sub_chunk_slice
// Desc     : Combinational W-bit ripple subtractor with borrow in and out.
// Revision : 1.0 - initial release
// ============================================================================
module sub_chunk_slice #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_borrow,
    output logic [W-1:0] o_diff,
    output logic         o_borrow
);

    logic [W:0] w_chain;

    assign w_chain[0] = i_borrow;

    generate
        for (genvar i = 0; i < W; i++) begin : g_bit
            logic w_x;
            assign w_x          = i_a[i] ^ i_b[i];
            assign o_diff[i]    = w_x ^ w_chain[i];
            // Borrow when b > a at this bit, or they match and a borrow ripples in.
            assign w_chain[i+1] = (~i_a[i] & i_b[i]) | (~w_x & w_chain[i]);
        end
    endgenerate

    assign o_borrow = w_chain[W];

endmodule
`default_nettype wire

// File: rtl/sub_chunked_serial.sv
`default_nettype none
// ============================================================================
// Module   : sub_chunked_serial
// Desc     : Streams C = A - B one W-bit chunk per beat, LS chunk first.
// Revision : 1.0 - initial release
// ============================================================================
module sub_chunked_serial
    import sub_chunked_pkg::*;
#(
    parameter  int N  = DEF_N,
    parameter  int CC = DEF_CC,
    localparam int W  = N / CC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] c,
    output logic         out_last,
    output logic         busy,
    output logic         done,
    output logic         borrow_out
);

    localparam int            C_CW   = cnt_width(CC);
    localparam logic [C_CW-1:0] C_LAST = C_CW'(CC - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [C_CW-1:0] r_cnt;
    logic            r_borrow;
    logic [W-1:0]    r_c;
    logic            r_out_valid;
    logic            r_out_last;
    logic            r_done;
    logic            r_borrow_out;

    logic            w_in_ready;
    logic            w_accept;
    logic            w_consume;
    logic            w_cnt_last;
    logic [W-1:0]    w_diff;
    logic            w_borrow_next;

    sub_chunk_slice #(
        .W (W)
    ) u_slice (
        .i_a      (a),
        .i_b      (b),
        .i_borrow (r_borrow),
        .o_diff   (w_diff),
        .o_borrow (w_borrow_next)
    );

    assign w_consume  = r_out_valid && out_ready;
    assign w_cnt_last = (r_cnt == C_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                // Single output register: a new beat may enter as the old one leaves.
                w_in_ready = !r_out_valid || out_ready;
                w_accept   = in_valid && w_in_ready;
                if (w_accept && w_cnt_last) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_consume) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_borrow     <= 1'b0;
            r_c          <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_done       <= 1'b0;
            r_borrow_out <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_c         <= w_diff;
                        r_borrow    <= w_borrow_next;
                        r_out_valid <= 1'b1;
                        r_out_last  <= w_cnt_last;
                        r_cnt       <= w_cnt_last ? '0 : r_cnt + 1'b1;
                    end else if (w_consume) begin
                        r_out_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (w_consume) begin
                        r_out_valid  <= 1'b0;
                        r_out_last   <= 1'b0;
                        r_done       <= 1'b1;
                        r_borrow_out <= r_borrow;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign c          = r_c;
    assign out_last   = r_out_last;
    assign busy       = (r_state == RUN) || (r_state == DRAIN);
    assign done       = r_done;
    assign borrow_out = r_borrow_out;

endmodule
`default_nettype wire

// File: tb/tb_sub_chunked_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_chunked_serial
// Desc     : Self-checking bench: 64-bit/4-beat instance plus a 16-bit/1-beat one.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sub_chunked_serial;

    localparam int N0  = 64;
    localparam int CC0 = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [15:0] a = '0, b = '0;
    logic        in_ready, out_valid, out_last, busy, done, borrow_out;
    logic [15:0] c;

    logic        start1 = 1'b0, in_valid1 = 1'b0, out_ready1 = 1'b1;
    logic [15:0] a1 = '0, b1 = '0;
    logic        in_ready1, out_valid1, out_last1, busy1, done1, borrow_out1;
    logic [15:0] c1;

    int          checks   = 0;
    int          failures = 0;
    int          or_mode  = 0;
    logic [15:0] exp_q[$];
    int          beat_idx = 0;
    logic [63:0] got_val  = '0;
    logic        exp_borrow  = 1'b0;
    logic        expect_done = 1'b0;

    sub_chunked_serial #(.N(N0), .CC(CC0)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .c(c),
        .out_last(out_last), .busy(busy), .done(done), .borrow_out(borrow_out)
    );

    sub_chunked_serial #(.N(16), .CC(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1), .c(c1),
        .out_last(out_last1), .busy(busy1), .done(done1), .borrow_out(borrow_out1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream ready pattern: 0 always ready, 1 ~30% stalls, 2 fully stalled.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 99) >= 30);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Compare process: every beat the collector takes is checked against the model.
    initial begin
        logic        prev_stall;
        logic [15:0] prev_c;
        logic        prev_last;
        logic [15:0] e;
        prev_stall = 1'b0;
        prev_c     = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                expect_done = 1'b0;
                prev_stall  = 1'b0;
                beat_idx    = 0;
            end else begin
                if (expect_done) begin
                    check("done_pulse", done, 1);
                    check("done_borrow", borrow_out, exp_borrow);
                    check("done_busy", busy, 0);
                    expect_done = 1'b0;
                end else begin
                    check("done_quiet", done, 0);
                end
                if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
                if (!busy) check("in_ready_idle", in_ready, 0);
                if (prev_stall) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_c", c, prev_c);
                    check("hold_last", out_last, prev_last);
                end
                if (out_valid && out_ready) begin
                    check("beat_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("beat_c", c, e);
                        check("beat_last", out_last, beat_idx == CC0 - 1);
                        if (beat_idx < CC0) got_val[beat_idx*16 +: 16] = c;
                        if (beat_idx == CC0 - 1) expect_done = 1'b1;
                        beat_idx++;
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_c     = c;
                prev_last  = out_last;
            end
        end
    end

    task automatic begin_op(input logic [63:0] A, input logic [63:0] B);
        logic [63:0] diff;
        diff = A - B;
        @(posedge clk); #1;
        start = 1'b1;
        for (int k = 0; k < CC0; k++) exp_q.push_back(diff[k*16 +: 16]);
        exp_borrow = (A < B);
        beat_idx   = 0;
        got_val    = '0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input logic [63:0] A, input logic [63:0] B, input int nbeats,
                        input bit gaps, input bit noise);
        int n;
        for (int k = 0; k < nbeats; k++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            a        = A[k*16 +: 16];
            b        = B[k*16 +: 16];
            in_valid = 1'b1;
            start    = noise && k[0];
            n = 0;
            do begin @(negedge clk); n++; end while (!in_ready && n < 200);
            if (!in_ready) check("in_ready_timeout", in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 500);
        check("done_seen", done, 1);
    endtask

    task automatic do_op(input logic [63:0] A, input logic [63:0] B, input bit gaps, input bit noise);
        int saved;
        begin_op(A, B);
        feed(A, B, CC0, gaps, noise);
        if (noise) begin
            saved   = or_mode;
            start   = 1'b1;
            or_mode = 2;
            repeat (3) begin @(posedge clk); #1; end
            start   = 1'b0;
            or_mode = saved;
        end
        wait_done();
        check("q_drained", exp_q.size(), 0);
        check("result", got_val, A - B);
        check("borrow_final", borrow_out, A < B);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ra, rb;
        int n;

        #2;
        check("rst_c", c, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_done", done, 0);
        check("rst_borrow_out", borrow_out, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst1_out_valid", out_valid1, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Hand-computed expectations
        or_mode = 0;
        do_op(64'h0000_0000_0001_0000, 64'h1, 1'b0, 1'b0);
        check("t1_literal", got_val, 64'h0000_0000_0000_FFFF);
        check("t1_borrow", borrow_out, 0);
        do_op(64'h0, 64'h1, 1'b0, 1'b0);
        check("t2_literal", got_val, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t2_borrow", borrow_out, 1);
        or_mode = 1;
        do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0);
        check("t3_literal", got_val, 64'h0246_8ACF_1357_9BCF);

        // Abort mid-operation with a live borrow, then confirm nothing stale survives
        or_mode = 0;
        begin_op(64'h0, 64'h1);
        feed(64'h0, 64'h1, 2, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_borrow_out", borrow_out, 0);
        check("abort_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        do_op(64'h5, 64'h3, 1'b0, 1'b0);
        check("t4_literal", got_val, 64'h2);

        // in_valid asserted in IDLE must not consume anything
        @(posedge clk); #1;
        in_valid = 1'b1;
        a = 16'($urandom);
        b = 16'($urandom);
        repeat (4) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        check("idle_no_op", busy, 0);
        do_op({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b1);

        // Randomized operands with stalls and source gaps
        or_mode = 1;
        for (int t = 0; t < 6; t++) begin
            ra = {$urandom, $urandom};
            rb = (t == 2) ? ra : {$urandom, $urandom};
            do_op(ra, rb, t[0], 1'b0);
        end
        or_mode = 0;

        // Single-beat instance
        @(posedge clk); #1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1    = 1'b0;
        a1        = 16'h0003;
        b1        = 16'h0005;
        in_valid1 = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!in_ready1 && n < 50);
        check("cc1_in_ready", in_ready1, 1);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        @(negedge clk);
        check("cc1_valid", out_valid1, 1);
        check("cc1_c", c1, 16'hFFFE);
        check("cc1_last", out_last1, 1);
        check("cc1_no_early_done", done1, 0);
        @(negedge clk);
        check("cc1_done", done1, 1);
        check("cc1_borrow", borrow_out1, 1);
        check("cc1_busy", busy1, 0);
        @(negedge clk);
        check("cc1_done_pulse", done1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
